// File: rtl/common_pkg.sv
// Shared arbitration types and limits for the Wishbone requester arbiter.
// Owner encoding doubles as the FSM state so owner_o is the state register itself.
package common_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_M0   = 2'd1,
        ARB_M1   = 2'd2
    } arb_owner_t;

    localparam logic [1:0] WB_ARB_MAX_OUTSTANDING = 2'd3;

    // Round-robin tie break: whoever did not own the bus last time wins.
    function automatic arb_owner_t arb_tie_winner(input arb_owner_t last_owner);
        arb_owner_t winner;
        if (last_owner == ARB_M1) begin
            winner = ARB_M0;
        end else begin
            winner = ARB_M1;
        end
        return winner;
    endfunction

endpackage

// File: rtl/wb_arbiter.sv
// Two-requester Wishbone B4 pipelined arbiter in front of the RAM controller.
// Ownership is held for a whole cycle_i; handovers always pass through IDLE.
module wb_arbiter
    import common_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 24,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_ni,
    input  logic                     wb_grant_i,

    input  logic                     m0_cycle_i,
    input  logic                     m0_strobe_i,
    input  logic                     m0_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0]    m0_data_i,
    output logic                     m0_stall_o,
    output logic                     m0_ack_o,
    output logic [DATA_WIDTH-1:0]    m0_data_o,

    input  logic                     m1_cycle_i,
    input  logic                     m1_strobe_i,
    input  logic                     m1_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0]    m1_data_i,
    output logic                     m1_stall_o,
    output logic                     m1_ack_o,
    output logic [DATA_WIDTH-1:0]    m1_data_o,

    output logic                     wb_cycle_o,
    output logic                     wb_strobe_o,
    output logic                     wb_we_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0]    wb_data_o,
    input  logic                     wb_stall_i,
    input  logic                     wb_ack_i,
    input  logic [DATA_WIDTH-1:0]    wb_data_i,

    output arb_owner_t               owner_o
);

    arb_owner_t r_state;
    arb_owner_t r_last_owner;
    logic [1:0] r_outstanding;

    logic w_own_m0;
    logic w_own_m1;
    logic w_sel_cycle;
    logic w_sel_strobe;
    logic w_full;
    logic w_stall;
    logic w_accept;
    logic w_ack_valid;

    // Select the owning requester's request lines and derive handshake qualifiers.
    always_comb begin
        w_own_m0     = (r_state == ARB_M0);
        w_own_m1     = (r_state == ARB_M1);
        w_sel_cycle  = 1'b0;
        w_sel_strobe = 1'b0;
        wb_we_o      = 1'b0;
        wb_addr_o    = '0;
        wb_data_o    = '0;
        if (w_own_m0) begin
            w_sel_cycle  = m0_cycle_i;
            w_sel_strobe = m0_strobe_i;
            wb_we_o      = m0_we_i;
            wb_addr_o    = m0_addr_i;
            wb_data_o    = m0_data_i;
        end else if (w_own_m1) begin
            w_sel_cycle  = m1_cycle_i;
            w_sel_strobe = m1_strobe_i;
            wb_we_o      = m1_we_i;
            wb_addr_o    = m1_addr_i;
            wb_data_o    = m1_data_i;
        end else begin
            w_sel_cycle  = 1'b0;
            w_sel_strobe = 1'b0;
        end
        w_full      = (r_outstanding == WB_ARB_MAX_OUTSTANDING);
        w_stall     = ~wb_grant_i | wb_stall_i | w_full;
        wb_cycle_o  = w_sel_cycle;
        wb_strobe_o = w_sel_strobe & wb_grant_i & ~w_full;
        w_accept    = wb_strobe_o & ~wb_stall_i;
        // Acks in IDLE or with nothing in flight are stale leftovers of an abort.
        w_ack_valid = wb_ack_i & (w_own_m0 | w_own_m1) & (r_outstanding != 2'd0);
    end

    assign m0_stall_o = w_own_m0 ? w_stall : 1'b1;
    assign m1_stall_o = w_own_m1 ? w_stall : 1'b1;
    assign m0_ack_o   = w_ack_valid & w_own_m0;
    assign m1_ack_o   = w_ack_valid & w_own_m1;
    assign m0_data_o  = wb_data_i;
    assign m1_data_o  = wb_data_i;
    assign owner_o    = r_state;

    // Ownership FSM, in-flight counter and round-robin history.
    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            r_state       <= ARB_IDLE;
            r_last_owner  <= ARB_M1;
            r_outstanding <= 2'd0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_outstanding <= 2'd0;
                    if (m0_cycle_i && m1_cycle_i) begin
                        r_state      <= arb_tie_winner(r_last_owner);
                        r_last_owner <= arb_tie_winner(r_last_owner);
                    end else if (m0_cycle_i) begin
                        r_state      <= ARB_M0;
                        r_last_owner <= ARB_M0;
                    end else if (m1_cycle_i) begin
                        r_state      <= ARB_M1;
                        r_last_owner <= ARB_M1;
                    end else begin
                        r_state      <= ARB_IDLE;
                    end
                end
                ARB_M0, ARB_M1: begin
                    if (!w_sel_cycle) begin
                        r_state       <= ARB_IDLE;
                        r_outstanding <= 2'd0;
                    end else if (w_accept && !w_ack_valid) begin
                        r_outstanding <= r_outstanding + 2'd1;
                    end else if (!w_accept && w_ack_valid) begin
                        r_outstanding <= r_outstanding - 2'd1;
                    end else begin
                        r_outstanding <= r_outstanding;
                    end
                end
                default: begin
                    r_state       <= ARB_IDLE;
                    r_outstanding <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scenarios plus a random phase, every cycle checked against a
// transaction-level model of ownership, round-robin and in-flight count.
module tb_wb_arbiter;
    import common_pkg::*;

    localparam int AW = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          grant;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdat, m1_wdat;
    logic          m0_stall, m0_ack, m1_stall, m1_ack;
    logic [DW-1:0] m0_rdat, m1_rdat;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_wdat;
    logic          wb_stall, wb_ack;
    logic [DW-1:0] wb_rdat;
    arb_owner_t    owner;

    int total = 0;
    int bad   = 0;
    int mown  = 0;   // 0 idle, 1 requester 0, 2 requester 1
    int mout  = 0;
    int mlast = 2;
    int m0_acks = 0;
    int m1_acks = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.WB_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .wb_clock_i(clk), .wb_reset_ni(rst_n), .wb_grant_i(grant),
        .m0_cycle_i(m0_cyc), .m0_strobe_i(m0_stb), .m0_we_i(m0_we),
        .m0_addr_i(m0_addr), .m0_data_i(m0_wdat),
        .m0_stall_o(m0_stall), .m0_ack_o(m0_ack), .m0_data_o(m0_rdat),
        .m1_cycle_i(m1_cyc), .m1_strobe_i(m1_stb), .m1_we_i(m1_we),
        .m1_addr_i(m1_addr), .m1_data_i(m1_wdat),
        .m1_stall_o(m1_stall), .m1_ack_o(m1_ack), .m1_data_o(m1_rdat),
        .wb_cycle_o(wb_cyc), .wb_strobe_o(wb_stb), .wb_we_o(wb_we),
        .wb_addr_o(wb_addr), .wb_data_o(wb_wdat),
        .wb_stall_i(wb_stall), .wb_ack_i(wb_ack), .wb_data_i(wb_rdat),
        .owner_o(owner)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] own_code(input int o);
        return (o == 1) ? 2'd1 : (o == 2) ? 2'd2 : 2'd0;
    endfunction

    // Check all outputs for the current inputs, then advance one clock and the model.
    task automatic step();
        logic cyc, stb, full, stall, estb, acc, ackv, e0s, e1s;
        #1;
        cyc   = (mown == 1) ? m0_cyc : (mown == 2) ? m1_cyc : 1'b0;
        stb   = (mown == 1) ? m0_stb : (mown == 2) ? m1_stb : 1'b0;
        full  = (mout == 3);
        stall = !grant || wb_stall || full;
        estb  = (mown != 0) && stb && grant && !full;
        acc   = estb && !wb_stall;
        ackv  = (mown != 0) && wb_ack && (mout > 0);
        e0s   = (mown == 1) ? stall : 1'b1;
        e1s   = (mown == 2) ? stall : 1'b1;
        chk("owner", owner, own_code(mown));
        chk("outstanding", dut.r_outstanding, mout);
        chk("wb_cycle", wb_cyc, cyc);
        chk("wb_strobe", wb_stb, estb);
        chk("m0_stall", m0_stall, e0s);
        chk("m1_stall", m1_stall, e1s);
        chk("m0_ack", m0_ack, ackv && mown == 1);
        chk("m1_ack", m1_ack, ackv && mown == 2);
        chk("m0_rdata", m0_rdat, wb_rdat);
        chk("m1_rdata", m1_rdat, wb_rdat);
        if (mown != 0) begin
            chk("wb_addr", wb_addr, (mown == 1) ? m0_addr : m1_addr);
            chk("wb_we", wb_we, (mown == 1) ? m0_we : m1_we);
            chk("wb_wdata", wb_wdat, (mown == 1) ? m0_wdat : m1_wdat);
        end
        if (m0_ack) m0_acks++;
        if (m1_ack) m1_acks++;
        @(posedge clk);
        if (mown == 0) begin
            mout = 0;
            if (m0_cyc && m1_cyc) begin
                mown = (mlast == 2) ? 1 : 2;
                mlast = mown;
            end else if (m0_cyc || m1_cyc) begin
                mown = m0_cyc ? 1 : 2;
                mlast = mown;
            end
        end else if (!cyc) begin
            mown = 0;
            mout = 0;
        end else begin
            mout = mout + (acc ? 1 : 0) - (ackv ? 1 : 0);
        end
        #1;
    endtask

    task automatic quiet();
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        wb_ack = 1'b0; wb_stall = 1'b0; grant = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        quiet();
        m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = 24'h000000; m1_addr = 24'h000000;
        m0_wdat = 16'h0000; m1_wdat = 16'h0000; wb_rdat = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_owner", owner, ARB_IDLE);
        chk("reset_m0_stall", m0_stall, 1'b1);
        chk("reset_m1_stall", m1_stall, 1'b1);
        chk("reset_wb_cycle", wb_cyc, 1'b0);
        rst_n = 1'b1;
        step();

        // Single requester read on requester 1.
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_addr = 24'h001000; wb_rdat = 16'hbeef;
        step();
        chk("single_owner_m1", owner, ARB_M1);
        step();
        m1_stb = 1'b0;
        step();
        step();
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        step();
        chk("single_m1_ack_count", m1_acks, 1);
        chk("single_m0_ack_count", m0_acks, 0);
        chk("single_outstanding_zero", dut.r_outstanding, 2'd0);
        m1_cyc = 1'b0;
        step();

        // Tie after reset history: M0 first, one idle clock, then M1; next tie M0 again.
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        step();
        chk("tie_first_m0", owner, ARB_M0);
        m0_cyc = 1'b0;
        step();
        chk("tie_idle_gap", owner, ARB_IDLE);
        step();
        chk("tie_then_m1", owner, ARB_M1);
        m1_cyc = 1'b0;
        step();
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        step();
        chk("tie_repeat_m0", owner, ARB_M0);
        quiet();
        step();

        // Pipelined burst with acks withheld: three accepted, fourth stalls until an ack.
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_addr = 24'h00abcd; m0_wdat = 16'h1234;
        step();
        repeat (3) step();
        #1;
        chk("pipe_full_stall", m0_stall, 1'b1);
        chk("pipe_full_nostrobe", wb_stb, 1'b0);
        step();
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        #1;
        chk("pipe_fourth_strobe", wb_stb, 1'b1);
        step();
        m0_stb = 1'b0; wb_ack = 1'b1;
        repeat (3) step();
        quiet();
        step();

        // Window closes mid-burst: strobe gated, stall forced, ownership kept.
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 24'h002000;
        step();
        step();
        grant = 1'b0;
        #1;
        chk("window_low_strobe", wb_stb, 1'b0);
        chk("window_low_stall", m1_stall, 1'b1);
        step();
        step();
        chk("window_owner_kept", owner, ARB_M1);
        grant = 1'b1;
        step();
        m1_stb = 1'b0; wb_ack = 1'b1;
        repeat (2) step();
        quiet();
        step();

        // Abort with two in flight, late ack arrives in IDLE alongside a new request.
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        step();
        step();
        chk("abort_two_outstanding", dut.r_outstanding, 2'd2);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        wb_ack = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        #1;
        chk("abort_late_ack_m0", m0_ack, 1'b0);
        chk("abort_late_ack_m1", m1_ack, 1'b0);
        step();
        wb_ack = 1'b0;
        step();
        chk("abort_new_grant_count", dut.r_outstanding, 2'd1);

        // Asynchronous reset mid-burst with one in flight.
        m1_stb = 1'b0;
        #2;
        rst_n = 1'b0; wb_ack = 1'b1;
        #1;
        chk("rst_async_owner", owner, ARB_IDLE);
        chk("rst_async_outstanding", dut.r_outstanding, 2'd0);
        chk("rst_async_m0_stall", m0_stall, 1'b1);
        chk("rst_async_m1_stall", m1_stall, 1'b1);
        chk("rst_async_m1_ack", m1_ack, 1'b0);
        chk("rst_async_wb_cycle", wb_cyc, 1'b0);
        chk("rst_async_wb_strobe", wb_stb, 1'b0);
        mown = 0; mout = 0; mlast = 2;
        quiet();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            m0_cyc   = ($urandom_range(0, 9) < 8);
            m1_cyc   = ($urandom_range(0, 9) < 7);
            m0_stb   = $urandom_range(0, 1);
            m1_stb   = $urandom_range(0, 1);
            m0_we    = $urandom_range(0, 1);
            m1_we    = $urandom_range(0, 1);
            m0_addr  = AW'($urandom);
            m1_addr  = AW'($urandom);
            m0_wdat  = DW'($urandom);
            m1_wdat  = DW'($urandom);
            wb_rdat  = DW'($urandom);
            grant    = ($urandom_range(0, 9) < 8);
            wb_stall = ($urandom_range(0, 9) < 2);
            wb_ack   = ($urandom_range(0, 9) < 3);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 wb_clock_i  in  1  system clock; all state changes on rising edge.
REQ-003 wb_reset_ni  in  1  asynchronous active-low reset.
REQ-004 wb_grant_i  in  1  Wishbone window from the timing block; peripheral strobes pass only while high.
REQ-005 m0_cycle_i, m0_strobe_i, m0_we_i  in  1 each  requester 0 (video fetch), Wishbone B4 pipelined.
REQ-006 m0_addr_i  in  WB_ADDR_WIDTH; m0_data_i  in  DATA_WIDTH.
REQ-007 m0_stall_o, m0_ack_o  out  1 each  requester 0 handshake.
REQ-008 m1_* ports SHALL mirror REQ-005..007 for requester 1 (SPI bridge).
REQ-009 wb_cycle_o, wb_strobe_o, wb_we_o  out  1; wb_addr_o  out  WB_ADDR_WIDTH; wb_data_o  out  DATA_WIDTH; these drive the RAM controller.
REQ-010 wb_stall_i, wb_ack_i  in  1; wb_data_i  in  DATA_WIDTH  from the RAM controller; wb_data_i SHALL be broadcast unregistered to both requesters as m0_data_o/m1_data_o.
REQ-011 owner_o  out  arb_owner_t  current owner, for debug/visibility.

Function
REQ-012 FSM states IDLE, OWN_M0, OWN_M1; owner_o SHALL equal the state.
REQ-013 IDLE: if only one requester has cycle_i high, the FSM SHALL enter that requester's OWN state at the next edge.
REQ-014 IDLE with both cycle_i high: round-robin; the requester NOT recorded in last_owner SHALL win; last_owner updates on every grant.
REQ-015 OWN_x: wb_cycle_o = mx_cycle_i; addr, we, and data SHALL be muxed combinationally from mx.
REQ-016 wb_strobe_o = mx_strobe_i & wb_grant_i & (outstanding < WB_ARB_MAX_OUTSTANDING).
REQ-017 mx_stall_o = ~wb_grant_i | wb_stall_i | (outstanding == WB_ARB_MAX_OUTSTANDING); the non-owner's stall SHALL be 1.
REQ-018 In IDLE, both stall outputs SHALL be 1 and wb_cycle_o/wb_strobe_o SHALL be 0; grant latency is one clock from cycle_i assertion to first possible strobe.
REQ-019 A 2-bit outstanding counter SHALL increment on an accepted strobe (wb_strobe_o & ~wb_stall_i) and decrement on wb_ack_i; on a simultaneous accept and ack it SHALL hold.
REQ-020 wb_ack_i SHALL be routed only to the owner's ack; an ack with outstanding == 0 or in IDLE SHALL be discarded, and the counter SHALL NOT underflow.
REQ-021 Release: when the owner deasserts cycle_i, the FSM SHALL return to IDLE at the next edge, regardless of outstanding; the counter SHALL clear to 0 (Wishbone abort semantics).
REQ-022 There SHALL be no direct OWN_M0<->OWN_M1 transition; every handover passes through IDLE, giving at least one idle clock.
REQ-023 wb_grant_i falling mid-transaction SHALL NOT release ownership; strobes SHALL resume when the window reopens.

Reset
REQ-024 On wb_reset_ni low: state=IDLE, outstanding=0, last_owner=M1 (so M0 wins the first tie), m0/m1_stall_o=1, all acks=0, wb_cycle_o=wb_strobe_o=0.
REQ-025 A reset asserted mid-transaction SHALL take effect immediately (asynchronously); outstanding acks arriving after release SHALL be discarded per REQ-020.

Structure
REQ-026 arb_owner_t (ARB_IDLE, ARB_M0, ARB_M1) and WB_ARB_MAX_OUTSTANDING=3 SHALL live in common_pkg.
REQ-027 The block SHALL be a single flat module with no sub-module, instantiated in system between the two requesters and the ram block's wb_strobe_i/wb_cycle_i gating.
REQ-028 The block SHALL use a single always_ff for state, counter, and last_owner, and SHALL use combinational muxing for the datapath.

Verification
REQ-029 Single requester: m1 issues a read to 0x1000 with wb_grant_i=1 and the RAM acking 2 clocks later -> owner=M1 one clock after cycle, exactly one m1_ack_o, no m0_ack_o, and outstanding returns to 0.
REQ-030 Tie: m0 and m1 assert cycle in the same clock after reset -> M0 is granted first; after m0 drops cycle, IDLE lasts one clock, then M1 is granted; a repeated tie is won by M0 again (last_owner=M1).
REQ-031 Pipelining: m0 issues 4 back-to-back strobes while the RAM withholds acks -> 3 are accepted, then m0_stall_o=1 for the 4th until the first ack, after which the 4th is accepted.
REQ-032 Window: wb_grant_i toggles 1,0,0,1 during an m1 burst -> wb_strobe_o=0 and m1_stall_o=1 while the window is low, and owner stays M1.
REQ-033 Abort: m0 drops cycle with 2 outstanding, then a late wb_ack_i arrives in IDLE -> the ack is discarded, outstanding=0, and a new m1 grant is unaffected.
REQ-034 Reset mid-burst: wb_reset_ni pulsed low while OWN_M1 with 1 outstanding -> all REQ-024 values appear immediately, without waiting for a clock edge.
